// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
// Contents:
//   REG_ADDR_W - register-file address width
//   REG_ZERO   - address of the hard-wired zero register
//   md_state_t - mult/div unit occupancy states
// The forwarding unit and decode import this package as well.
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   md_start - mult/div issuing in EX this cycle
//   md_busy  - unit occupied (registered), MD_LATENCY cycles after issue
//   md_done  - one-cycle pulse the cycle after the last busy cycle
//
// state   | meaning
// MD_IDLE | unit free, accepts a new issue
// MD_BUSY | unit computing, md_cnt counts remaining busy cycles minus one
module hazard_stall_ctrl_md_busy_tracker
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  output logic md_busy,
  output logic md_done
);

  localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 1);

  md_state_t state, state_nxt;
  logic [CW-1:0] md_cnt, md_cnt_nxt;
  logic done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_cnt  <= md_cnt_nxt;
      md_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    done_nxt   = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (md_start) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        // A start seen here is illegal and deliberately ignored.
        if (md_cnt == '0) begin
          state_nxt = MD_IDLE;
          done_nxt  = 1'b1;
        end else begin
          md_cnt_nxt = md_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt  = MD_IDLE;
        md_cnt_nxt = '0;
      end
    endcase
  end

  assign md_busy = (state == MD_BUSY);

  md_start_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) (state == MD_BUSY) |-> !md_start
  );

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch flush,
// saturating stall-cycle counter.
// Ports:
//   clk, rst_n            - clock (rising edge), synchronous active-low reset
//   Rs_ID, Rt_ID          - source registers of the ID instruction
//   Uses_Rt_ID            - ID instruction reads rt
//   Rt_EX, Mem_Read_EX    - EX destination and load flag
//   MD_Start_EX           - mult/div issuing in EX
//   MD_Op_ID, MF_HiLo_ID  - ID instruction is mult/div or mfhi/mflo
//   Branch_Taken          - branch/jump resolved taken in ID
//   PC_Write, IF_ID_Write - front-end load enables (low while stalling)
//   IF_ID_Flush           - zero IF/ID on next edge
//   ID_EX_Flush           - insert bubble into ID/EX on next edge
//   MD_Busy, MD_Done      - mult/div occupancy and completion pulse
//   Stall_Cycles          - saturating count of stalled cycles
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic                  Uses_Rt_ID,
  input  logic [REG_ADDR_W-1:0] Rt_EX,
  input  logic                  Mem_Read_EX,
  input  logic                  MD_Start_EX,
  input  logic                  MD_Op_ID,
  input  logic                  MF_HiLo_ID,
  input  logic                  Branch_Taken,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
  output logic                  MD_Busy,
  output logic                  MD_Done,
  output logic [CNT_W-1:0]      Stall_Cycles
);

  logic md_busy_q;
  logic load_haz;
  logic md_haz;
  logic stall;

  hazard_stall_ctrl_md_busy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .md_start(MD_Start_EX),
    .md_busy (md_busy_q),
    .md_done (MD_Done)
  );

  // Outputs are held at their pass-through values while reset is low,
  // including the cycle before the first reset edge lands.
  assign MD_Busy = rst_n & md_busy_q;

  assign load_haz = Mem_Read_EX && (Rt_EX != REG_ZERO) &&
                    ((Rt_EX == Rs_ID) || (Uses_Rt_ID && (Rt_EX == Rt_ID)));
  assign md_haz   = MD_Busy && (MF_HiLo_ID || MD_Op_ID);
  assign stall    = rst_n && (load_haz || md_haz);

  assign PC_Write    = ~stall;
  assign IF_ID_Write = ~stall;
  assign ID_EX_Flush = stall;
  // A stalled branch may depend on the stalled operand; it resolves again
  // next cycle, so the flush is suppressed here.
  assign IF_ID_Flush = rst_n && Branch_Taken && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Stall_Cycles <= '0;
    end else if (stall && (Stall_Cycles != {CNT_W{1'b1}})) begin
      Stall_Cycles <= Stall_Cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int MD_LAT = 4;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs, rt;
    logic       uses_rt;
    logic [4:0] rt_ex;
    logic       mem_rd, md_start, md_op, mf_hilo, br;
  } in_t;

  typedef struct {
    logic pc_w, ifid_w, ifid_fl, idex_fl, busy, done;
    int   cnt, cnt4;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs_ID, Rt_ID, Rt_EX;
  logic Uses_Rt_ID, Mem_Read_EX, MD_Start_EX, MD_Op_ID, MF_HiLo_ID, Branch_Taken;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Busy, MD_Done;
  logic [15:0] Stall_Cycles;
  logic PC_Write4, IF_ID_Write4, IF_ID_Flush4, ID_EX_Flush4, MD_Busy4, MD_Done4;
  logic [3:0] Stall_Cycles4;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_rem  = 0;   // busy cycles still to come
  bit m_done = 0;
  int m_cnt  = 0;
  int m_cnt4 = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Uses_Rt_ID(Uses_Rt_ID),
    .Rt_EX(Rt_EX), .Mem_Read_EX(Mem_Read_EX), .MD_Start_EX(MD_Start_EX),
    .MD_Op_ID(MD_Op_ID), .MF_HiLo_ID(MF_HiLo_ID), .Branch_Taken(Branch_Taken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .MD_Busy(MD_Busy), .MD_Done(MD_Done),
    .Stall_Cycles(Stall_Cycles)
  );

  hazard_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Uses_Rt_ID(Uses_Rt_ID),
    .Rt_EX(Rt_EX), .Mem_Read_EX(Mem_Read_EX), .MD_Start_EX(MD_Start_EX),
    .MD_Op_ID(MD_Op_ID), .MF_HiLo_ID(MF_HiLo_ID), .Branch_Taken(Branch_Taken),
    .PC_Write(PC_Write4), .IF_ID_Write(IF_ID_Write4), .IF_ID_Flush(IF_ID_Flush4),
    .ID_EX_Flush(ID_EX_Flush4), .MD_Busy(MD_Busy4), .MD_Done(MD_Done4),
    .Stall_Cycles(Stall_Cycles4)
  );

  function automatic vec_t mk(bit r, int rs, int rt, bit u, int rtex, bit mr, bit ms,
                              bit mo, bit mf, bit br, bit pw, bit iw, bit ifl, bit efl,
                              bit bz, bit dn, int cnt);
    vec_t v;
    v.i.rst_n = r;  v.i.rs = 5'(rs); v.i.rt = 5'(rt); v.i.uses_rt = u;
    v.i.rt_ex = 5'(rtex); v.i.mem_rd = mr; v.i.md_start = ms; v.i.md_op = mo;
    v.i.mf_hilo = mf; v.i.br = br;
    v.o.pc_w = pw; v.o.ifid_w = iw; v.o.ifid_fl = ifl; v.o.idex_fl = efl;
    v.o.busy = bz; v.o.done = dn; v.o.cnt = cnt; v.o.cnt4 = (cnt > 15) ? 15 : cnt;
    return v;
  endfunction

  // Expected outputs for the current cycle from the hazard rules and the
  // model's notion of how many busy cycles remain.
  function automatic out_t model_out(input in_t v);
    out_t o;
    bit busy, lh, mh, st;
    busy = v.rst_n && (m_rem > 0);
    lh = v.mem_rd && (v.rt_ex != 0) &&
         ((v.rt_ex == v.rs) || (v.uses_rt && (v.rt_ex == v.rt)));
    mh = busy && (v.mf_hilo || v.md_op);
    st = v.rst_n && (lh || mh);
    o.pc_w = !st; o.ifid_w = !st; o.idex_fl = st;
    o.ifid_fl = v.rst_n && v.br && !st;
    o.busy = busy; o.done = m_done; o.cnt = m_cnt; o.cnt4 = m_cnt4;
    return o;
  endfunction

  task automatic model_clock(input in_t v, input bit st);
    if (!v.rst_n) begin
      m_rem = 0; m_done = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      m_done = (m_rem == 1);
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (v.md_start) m_rem = MD_LAT;
      if (st) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
    end
  endtask

  task automatic drive(input in_t v);
    rst_n = v.rst_n; Rs_ID = v.rs; Rt_ID = v.rt; Uses_Rt_ID = v.uses_rt;
    Rt_EX = v.rt_ex; Mem_Read_EX = v.mem_rd; MD_Start_EX = v.md_start;
    MD_Op_ID = v.md_op; MF_HiLo_ID = v.mf_hilo; Branch_Taken = v.br;
  endtask

  task automatic chk1(input string tag, input string fld, input logic got, input logic exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s %s got %b expected %b", tag, fld, got, exp);
    end
  endtask

  task automatic check(input out_t e, input string tag);
    int c16, c4;
    c16 = e.cnt;
    c4  = e.cnt4;
    n_vec++;
    chk1(tag, "PC_Write", PC_Write, e.pc_w);
    chk1(tag, "IF_ID_Write", IF_ID_Write, e.ifid_w);
    chk1(tag, "IF_ID_Flush", IF_ID_Flush, e.ifid_fl);
    chk1(tag, "ID_EX_Flush", ID_EX_Flush, e.idex_fl);
    chk1(tag, "MD_Busy", MD_Busy, e.busy);
    chk1(tag, "MD_Done", MD_Done, e.done);
    chk1(tag, "PC_Write(w4)", PC_Write4, e.pc_w);
    chk1(tag, "ID_EX_Flush(w4)", ID_EX_Flush4, e.idex_fl);
    chk1(tag, "IF_ID_Flush(w4)", IF_ID_Flush4, e.ifid_fl);
    chk1(tag, "IF_ID_Write(w4)", IF_ID_Write4, e.ifid_w);
    chk1(tag, "MD_Busy(w4)", MD_Busy4, e.busy);
    chk1(tag, "MD_Done(w4)", MD_Done4, e.done);
    if (Stall_Cycles !== c16[15:0]) begin
      n_err++;
      $display("FAIL %s Stall_Cycles got %0d expected %0d", tag, Stall_Cycles, c16);
    end
    if (Stall_Cycles4 !== c4[3:0]) begin
      n_err++;
      $display("FAIL %s Stall_Cycles(w4) got %0d expected %0d", tag, Stall_Cycles4, c4);
    end
  endtask

  // Inputs are applied just after a rising edge, outputs sampled on the
  // falling edge, then the model advances with the rising edge.
  task automatic run_vec(input in_t v, input out_t e, input string tag);
    out_t m;
    drive(v);
    m = model_out(v);
    @(negedge clk);
    check(e, tag);
    @(posedge clk);
    model_clock(v, m.idex_fl);
    #1;
  endtask

  vec_t tbl[21];
  vec_t rv;
  in_t  vi;

  initial begin
    //            r rs rt u rtex mr ms mo mf br | pw iw ifl efl bz dn cnt
    tbl[0]  = mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 8, 2, 0, 8, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 3, 9, 0, 9, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 3, 9, 1, 9, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1);
    tbl[5]  = mk(1, 8, 2, 0, 8, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 2);
    tbl[6]  = mk(1, 8, 2, 0, 8, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0, 2);
    tbl[7]  = mk(1, 8, 2, 0, 8, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 3);
    tbl[8]  = mk(1, 1, 2, 0, 3, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 3);
    tbl[9]  = mk(1, 1, 2, 0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 3);
    tbl[10] = mk(1, 1, 2, 0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 4);
    tbl[11] = mk(1, 1, 2, 0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 5);
    tbl[12] = mk(1, 1, 2, 0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 6);
    tbl[13] = mk(1, 1, 2, 0, 3, 0, 1, 0, 1, 0,  1, 1, 0, 0, 0, 1, 7);
    tbl[14] = mk(1, 1, 2, 0, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 7);
    tbl[15] = mk(1, 1, 2, 0, 3, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 0, 7);
    tbl[16] = mk(0, 1, 2, 0, 1, 1, 0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 8);
    tbl[17] = mk(1, 1, 2, 0, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 1, 2, 0, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[19] = mk(1, 1, 2, 0, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 1, 2, 0, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);

    // initial reset, two edges
    rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    drive(rv.i);
    @(posedge clk);
    @(posedge clk);
    model_clock(rv.i, 1'b0);
    #1;
    run_vec(rv.i, rv.o, "reset_state");

    for (int k = 0; k < 21; k++) begin
      run_vec(tbl[k].i, tbl[k].o, $sformatf("table%0d", k));
    end

    // saturation: 20 load-use stall cycles from a fresh reset
    run_vec(rv.i, model_out(rv.i), "sat_reset");
    for (int k = 0; k < 20; k++) begin
      rv = mk(1, 8, 2, 0, 8, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, k);
      run_vec(rv.i, rv.o, $sformatf("sat%0d", k));
    end
    rv = mk(1, 1, 2, 0, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 20);
    run_vec(rv.i, rv.o, "sat_hold");

    // randomized traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      vi.rst_n   = ($urandom_range(0, 49) != 0);
      vi.rs      = 5'($urandom_range(0, 3));
      vi.rt      = 5'($urandom_range(0, 3));
      vi.uses_rt = 1'($urandom_range(0, 1));
      vi.rt_ex   = 5'($urandom_range(0, 3));
      vi.mem_rd  = 1'($urandom_range(0, 1));
      vi.md_start = (m_rem == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      vi.md_op   = ($urandom_range(0, 3) == 0);
      vi.mf_hilo = ($urandom_range(0, 3) == 0);
      vi.br      = 1'($urandom_range(0, 1));
      run_vec(vi, model_out(vi), $sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
